// File: rtl/mgt_01_div_unit_pkg.sv
// rtl/mgt_01_div_unit_pkg.sv - shared types and constants for the radix-2 restoring divider
package mgt_01_div_unit_pkg;

    localparam int XLEN           = 32;
    localparam int DIV_ITERATIONS = XLEN;
    localparam int DIV_CNT_W      = $clog2(DIV_ITERATIONS);

    typedef enum logic [1:0] {
        DIV_  = 2'd0,
        DIVU_ = 2'd1,
        REM_  = 2'd2,
        REMU_ = 2'd3
    } div_ops_e;

    typedef enum logic {
        FREE = 1'b0,
        BUSY = 1'b1
    } fu_state_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2
    } div_state_e;

    function automatic logic [XLEN-1:0] cond_negate(input logic [XLEN-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    function automatic logic is_signed_op(input div_ops_e op);
        return (op == DIV_) || (op == REM_);
    endfunction

endpackage

// File: rtl/mgt_01_div_step.sv
// rtl/mgt_01_div_step.sv - one combinational restoring step: shift {R,Q} left, subtract D when it fits
module mgt_01_div_step
    import mgt_01_div_unit_pkg::*;
(
    input  logic [XLEN-1:0] i_rem,
    input  logic [XLEN-1:0] i_quo,
    input  logic [XLEN-1:0] i_div,
    output logic [XLEN-1:0] o_rem,
    output logic [XLEN-1:0] o_quo
);

    logic [XLEN:0] w_shifted;
    logic          w_ge;

    assign w_shifted = {i_rem, i_quo[XLEN-1]};
    assign w_ge      = (w_shifted >= {1'b0, i_div});
    // The restored remainder is always below D, so it fits back into XLEN bits.
    assign o_rem     = w_ge ? (w_shifted[XLEN-1:0] - i_div) : w_shifted[XLEN-1:0];
    assign o_quo     = {i_quo[XLEN-2:0], w_ge};

endmodule

// File: rtl/mgt_01_div_unit.sv
// rtl/mgt_01_div_unit.sv - iterative RV32M divider FU; DIV_FAST_SPECIAL_EN enables one-cycle x/0 and overflow
module mgt_01_div_unit
    import mgt_01_div_unit_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            clk_en_i,
    input  logic            valid_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    input  div_ops_e        operation_i,
    output logic [XLEN-1:0] result_o,
    output logic            valid_o,
    output fu_state_e       fu_state_o
);

    div_state_e           r_state;
    div_state_e           w_state_nxt;
    logic [DIV_CNT_W-1:0] r_cnt;
    logic [XLEN-1:0]      r_q;
    logic [XLEN-1:0]      r_r;
    logic [XLEN-1:0]      r_d;
    div_ops_e             r_op;
    logic                 r_neg_dvd;
    logic                 r_neg_dvs;

    logic            w_in_signed;
    logic            w_in_neg_dvd;
    logic            w_in_neg_dvs;
    logic [XLEN-1:0] w_in_dvd_mag;
    logic [XLEN-1:0] w_in_dvs_mag;
    logic            w_special;
    logic            w_div_zero;
    logic [XLEN-1:0] w_q_step;
    logic [XLEN-1:0] w_r_step;
    logic            w_neg_q;
    logic            w_neg_r;
    logic [XLEN-1:0] w_q_fix;
    logic [XLEN-1:0] w_r_fix;
    logic            w_is_div;

    assign w_in_signed  = is_signed_op(operation_i);
    assign w_in_neg_dvd = w_in_signed & dividend_i[XLEN-1];
    assign w_in_neg_dvs = w_in_signed & divisor_i[XLEN-1];
    assign w_in_dvd_mag = cond_negate(dividend_i, w_in_neg_dvd);
    assign w_in_dvs_mag = cond_negate(divisor_i, w_in_neg_dvs);
    assign w_div_zero   = (divisor_i == '0);

`ifdef DIV_FAST_SPECIAL_EN
    assign w_special = w_div_zero |
                       (w_in_signed & (dividend_i == {1'b1, {(XLEN-1){1'b0}}}) & (divisor_i == '1));
`else
    assign w_special = 1'b0;
`endif

    mgt_01_div_step u_step (
        .i_rem (r_r),
        .i_quo (r_q),
        .i_div (r_d),
        .o_rem (w_r_step),
        .o_quo (w_q_step)
    );

    // Zero divisor keeps the all-ones quotient regardless of operand signs.
    assign w_neg_q  = is_signed_op(r_op) & (r_neg_dvd ^ r_neg_dvs) & (r_d != '0);
    assign w_neg_r  = is_signed_op(r_op) & r_neg_dvd;
    assign w_q_fix  = cond_negate(r_q, w_neg_q);
    assign w_r_fix  = cond_negate(r_r, w_neg_r);
    assign w_is_div = (r_op == DIV_) || (r_op == DIVU_);

    assign fu_state_o = (r_state == IDLE) ? FREE : BUSY;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= IDLE;
        end else if (clk_en_i) begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (valid_i) w_state_nxt = w_special ? FIX : ITER;
            ITER:    if (r_cnt == DIV_CNT_W'(DIV_ITERATIONS - 1)) w_state_nxt = FIX;
            FIX:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cnt     <= '0;
            r_q       <= '0;
            r_r       <= '0;
            r_d       <= '0;
            r_op      <= DIV_;
            r_neg_dvd <= 1'b0;
            r_neg_dvs <= 1'b0;
            result_o  <= '0;
            valid_o   <= 1'b0;
        end else if (clk_en_i) begin
            valid_o <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (valid_i) begin
                        r_op      <= operation_i;
                        r_neg_dvd <= w_in_neg_dvd;
                        r_neg_dvs <= w_in_neg_dvs;
                        r_d       <= w_in_dvs_mag;
                        r_cnt     <= '0;
                        if (w_special && w_div_zero) begin
                            r_q <= '1;
                            r_r <= w_in_dvd_mag;
                        end else if (w_special) begin
                            r_q <= {1'b1, {(XLEN-1){1'b0}}};
                            r_r <= '0;
                        end else begin
                            r_q <= w_in_dvd_mag;
                            r_r <= '0;
                        end
                    end
                end
                ITER: begin
                    r_q   <= w_q_step;
                    r_r   <= w_r_step;
                    r_cnt <= r_cnt + 1'b1;
                end
                FIX: begin
                    result_o <= w_is_div ? w_q_fix : w_r_fix;
                    valid_o  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mgt_01_div_unit.sv
// tb/tb_mgt_01_div_unit.sv - scoreboard bench for mgt_01_div_unit
module tb_mgt_01_div_unit;
    import mgt_01_div_unit_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            clk_en;
    logic            valid_in;
    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] divisor;
    div_ops_e        op;
    logic [XLEN-1:0] result;
    logic            valid_out;
    fu_state_e       fu_state;

    mgt_01_div_unit dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .clk_en_i    (clk_en),
        .valid_i     (valid_in),
        .dividend_i  (dividend),
        .divisor_i   (divisor),
        .operation_i (op),
        .result_o    (result),
        .valid_o     (valid_out),
        .fu_state_o  (fu_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [XLEN-1:0] res;
        int              acc;
        int              lat;
        string           name;
    } exp_t;

    exp_t sb[$];
    int   edge_cnt = 0;
    int   n_checks = 0;
    int   n_errors = 0;

`ifdef DIV_FAST_SPECIAL_EN
    localparam int SPECIAL_LAT = 1;
`else
    localparam int SPECIAL_LAT = 33;
`endif
    localparam int NORMAL_LAT = 33;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && valid_out) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_valid: got result 0x%08h expected no output", result);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_result"}, result, e.res);
                chk({e.name, "_latency"}, XLEN'(edge_cnt - e.acc), XLEN'(e.lat));
            end
        end
    end

    task automatic issue(input div_ops_e o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [XLEN-1:0] exp, input int lat, input string nm);
        @(negedge clk);
        valid_in = 1'b1;
        op       = o;
        dividend = a;
        divisor  = b;
        sb.push_back('{exp, edge_cnt + 1, lat, nm});
        @(negedge clk);
        valid_in = 1'b0;
        op       = (o == DIV_) ? REMU_ : DIV_;
        dividend = $urandom;
        divisor  = $urandom;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL timeout: got %0d pending results expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic run(input div_ops_e o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [XLEN-1:0] exp, input int lat, input string nm);
        issue(o, a, b, exp, lat, nm);
        wait_done();
    endtask

    initial begin
        rst_n    = 1'b0;
        clk_en   = 1'b1;
        valid_in = 1'b0;
        op       = DIV_;
        dividend = '0;
        divisor  = '0;
        #12;
        chk("reset_result", result, '0);
        chk("reset_valid", XLEN'(valid_out), '0);
        chk("reset_fu_state", XLEN'(fu_state), XLEN'(FREE));
        @(negedge clk);
        rst_n = 1'b1;

        run(DIV_,  32'd100, 32'd7, 32'd14, NORMAL_LAT, "div_100_7");
        run(REM_,  32'd100, 32'd7, 32'd2,  NORMAL_LAT, "rem_100_7");
        run(DIVU_, 32'd100, 32'd7, 32'd14, NORMAL_LAT, "divu_100_7");
        run(REMU_, 32'd100, 32'd7, 32'd2,  NORMAL_LAT, "remu_100_7");
        run(DIV_,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, NORMAL_LAT, "div_m7_2");
        run(REM_,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, NORMAL_LAT, "rem_m7_2");
        run(DIVU_, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, NORMAL_LAT, "divu_big_2");
        run(DIV_,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, NORMAL_LAT, "div_7_m2");
        run(REM_,  32'd7, 32'hFFFF_FFFE, 32'd1,         NORMAL_LAT, "rem_7_m2");
        run(REMU_, 32'hFFFF_FFFF, 32'h10, 32'hF,        NORMAL_LAT, "remu_max_16");
        run(DIVU_, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, NORMAL_LAT, "divu_max_1");
        run(DIV_,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, SPECIAL_LAT, "div_m5_0");
        run(REM_,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, SPECIAL_LAT, "rem_m5_0");
        run(DIVU_, 32'd7, 32'd0, 32'hFFFF_FFFF, SPECIAL_LAT, "divu_7_0");
        run(REMU_, 32'd7, 32'd0, 32'd7,         SPECIAL_LAT, "remu_7_0");
        run(DIV_,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPECIAL_LAT, "div_ovf");
        run(REM_,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         SPECIAL_LAT, "rem_ovf");

        issue(DIV_, 32'd100, 32'd7, 32'd14, NORMAL_LAT + 5, "div_stall");
        repeat (8) @(negedge clk);
        clk_en   = 1'b0;
        valid_in = 1'b1;
        op       = REM_;
        dividend = 32'd55;
        divisor  = 32'd3;
        repeat (5) @(negedge clk);
        clk_en = 1'b1;
        repeat (3) @(negedge clk);
        valid_in = 1'b0;
        wait_done();
        repeat (40) @(negedge clk);
        chk("no_second_op_state", XLEN'(fu_state), XLEN'(FREE));

        issue(DIV_, 32'd200, 32'd9, 32'd22, NORMAL_LAT, "div_aborted");
        repeat (10) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_result", result, '0);
        chk("async_reset_valid", XLEN'(valid_out), '0);
        chk("async_reset_fu_state", XLEN'(fu_state), XLEN'(FREE));
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        run(DIV_, 32'd100, 32'd7, 32'd14, NORMAL_LAT, "div_after_reset");

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
